// File: rtl/greedysnake_pkg.sv
// Shared GreedySnake definitions: direction/mode codes, position-update states, grid defaults.
package greedysnake_pkg;

    localparam int unsigned GRID_W_DEF = 32;
    localparam int unsigned GRID_H_DEF = 24;

    localparam logic [1:0] FWD_X_UP   = 2'b00;
    localparam logic [1:0] FWD_X_DOWN = 2'b01;
    localparam logic [1:0] FWD_Y_UP   = 2'b10;
    localparam logic [1:0] FWD_Y_DOWN = 2'b11;

    localparam logic [3:0] MODE_RESET_SNAKE = 4'd0;
    localparam logic [3:0] MODE_UPDATE_POS  = 4'd1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_INIT,
        ST_CALC,
        ST_SCAN,
        ST_ERASE,
        ST_DRAW,
        ST_DONE,
        ST_OVER
    } state_e;

endpackage

// File: rtl/greedysnake_body_ring.sv
// Snake body ring buffer: head push, tail pop, tail-side append for initial build,
// indexed read (index 0 = head) and a dedicated tail read port.
module greedysnake_body_ring #(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned X_W     = 5,
    parameter int unsigned Y_W     = 5,
    localparam int unsigned IDX_W  = $clog2(MAX_LEN),
    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             append_i,
    input  logic [X_W-1:0]   wr_x_i,
    input  logic [Y_W-1:0]   wr_y_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [X_W-1:0]   rd_x_o,
    output logic [Y_W-1:0]   rd_y_o,
    output logic [X_W-1:0]   tail_x_o,
    output logic [Y_W-1:0]   tail_y_o,
    output logic [LEN_W-1:0] len_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [X_W-1:0]   mem_x_q [MAX_LEN];
    logic [Y_W-1:0]   mem_y_q [MAX_LEN];
    logic [IDX_W-1:0] head_ptr_q, head_ptr_d;
    logic [IDX_W-1:0] wr_ptr_c, rd_ptr_c, tail_ptr_c;
    logic [LEN_W-1:0] len_q, len_d;

    // Append writes just past the current tail; push writes one slot ahead of the head.
    always_comb begin
        head_ptr_d = head_ptr_q;
        len_d      = len_q;
        wr_ptr_c   = head_ptr_q - IDX_W'(len_q);
        if (clr_i) begin
            len_d = '0;
        end else begin
            if (push_i) begin
                head_ptr_d = head_ptr_q + IDX_W'(1);
                wr_ptr_c   = head_ptr_q + IDX_W'(1);
            end
            len_d = len_q + LEN_W'(push_i | append_i) - LEN_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr_q <= '0;
            len_q      <= '0;
        end else begin
            head_ptr_q <= head_ptr_d;
            len_q      <= len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_i && (push_i || append_i)) begin
            mem_x_q[wr_ptr_c] <= wr_x_i;
            mem_y_q[wr_ptr_c] <= wr_y_i;
        end
    end

    assign rd_ptr_c   = head_ptr_q - rd_idx_i;
    assign tail_ptr_c = head_ptr_q - IDX_W'(len_q - LEN_W'(1));
    assign rd_x_o     = mem_x_q[rd_ptr_c];
    assign rd_y_o     = mem_y_q[rd_ptr_c];
    assign tail_x_o   = mem_x_q[tail_ptr_c];
    assign tail_y_o   = mem_y_q[tail_ptr_c];
    assign len_o      = len_q;
    assign full_o     = (len_q == LEN_W'(MAX_LEN));
    assign empty_o    = (len_q == '0);

endmodule

// File: rtl/greedysnake_pos_update.sv
// GreedySnake position update: advances the snake per controller strobe, detects
// wall/self collision and food, and mirrors body changes into the grid BSRAM.
module greedysnake_pos_update
    import greedysnake_pkg::*;
#(
    parameter int unsigned GRID_W   = GRID_W_DEF,
    parameter int unsigned GRID_H   = GRID_H_DEF,
    parameter int unsigned X_W      = 5,
    parameter int unsigned Y_W      = 5,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned MAX_LEN  = 64,
    parameter int unsigned INIT_LEN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [1:0]        i_forward,
    input  logic [3:0]        i_mode,
    input  logic [X_W-1:0]    i_food_x,
    input  logic [Y_W-1:0]    i_food_y,
    output logic [X_W-1:0]    o_head_x,
    output logic [Y_W-1:0]    o_head_y,
    output logic [6:0]        o_len,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_eat,
    output logic              o_game_over,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_wr_data
);

    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned IDX_W = $clog2(MAX_LEN);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return ADDR_W'(ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x));
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [1:0]        dir_q, dir_d;
    logic [X_W-1:0]    food_x_q, food_x_d, nxt_x_q, nxt_x_d, head_x_q, head_x_d;
    logic [Y_W-1:0]    food_y_q, food_y_d, nxt_y_q, nxt_y_d, head_y_q, head_y_d;
    logic              eat_q, eat_d, go_q, go_d;
    logic              busy_q, busy_d, done_q, done_d, eat_pulse_q, eat_pulse_d;
    logic              wr_en_q, wr_en_d, wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

    logic              ring_clr, ring_push, ring_pop, ring_append;
    logic [X_W-1:0]    ring_wx, scan_x, tail_x;
    logic [Y_W-1:0]    ring_wy, scan_y, tail_y;
    logic [LEN_W-1:0]  ring_len;
    logic              ring_full, ring_empty;

    logic [X_W-1:0]    calc_x_c;
    logic [Y_W-1:0]    calc_y_c;
    logic              wall_c, calc_eat_c, grow_c, rst_cmd_c, upd_cmd_c;
    logic [ADDR_W-1:0] scan_last_c;

    greedysnake_body_ring #(
        .MAX_LEN (MAX_LEN),
        .X_W     (X_W),
        .Y_W     (Y_W)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (ring_clr),
        .push_i   (ring_push),
        .pop_i    (ring_pop),
        .append_i (ring_append),
        .wr_x_i   (ring_wx),
        .wr_y_i   (ring_wy),
        .rd_idx_i (IDX_W'(cnt_q)),
        .rd_x_o   (scan_x),
        .rd_y_o   (scan_y),
        .tail_x_o (tail_x),
        .tail_y_o (tail_y),
        .len_o    (ring_len),
        .full_o   (ring_full),
        .empty_o  (ring_empty)
    );

    // Candidate next head and wall test for the latched direction.
    always_comb begin
        calc_x_c = head_x_q;
        calc_y_c = head_y_q;
        wall_c   = 1'b0;
        case (dir_q)
            FWD_X_UP: begin
                wall_c   = (head_x_q == X_W'(GRID_W - 1));
                calc_x_c = head_x_q + X_W'(1);
            end
            FWD_X_DOWN: begin
                wall_c   = (head_x_q == '0);
                calc_x_c = head_x_q - X_W'(1);
            end
            FWD_Y_UP: begin
                wall_c   = (head_y_q == Y_W'(GRID_H - 1));
                calc_y_c = head_y_q + Y_W'(1);
            end
            default: begin
                wall_c   = (head_y_q == '0);
                calc_y_c = head_y_q - Y_W'(1);
            end
        endcase
    end

    assign calc_eat_c  = (calc_x_c == food_x_q) && (calc_y_c == food_y_q);
    assign grow_c      = eat_q && !ring_full;
    assign scan_last_c = grow_c ? ADDR_W'(ring_len) - ADDR_W'(1) : ADDR_W'(ring_len) - ADDR_W'(2);
    assign rst_cmd_c   = i_en && (i_mode == MODE_RESET_SNAKE);
    assign upd_cmd_c   = i_en && (i_mode == MODE_UPDATE_POS);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        food_x_d    = food_x_q;
        food_y_d    = food_y_q;
        nxt_x_d     = nxt_x_q;
        nxt_y_d     = nxt_y_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        eat_d       = eat_q;
        go_d        = go_q;
        ring_clr    = 1'b0;
        ring_push   = 1'b0;
        ring_pop    = 1'b0;
        ring_append = 1'b0;
        ring_wx     = nxt_x_q;
        ring_wy     = nxt_y_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = '0;
        wr_data_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (upd_cmd_c && !ring_empty && !go_q) begin
                    state_d  = ST_CALC;
                    dir_d    = i_forward;
                    food_x_d = i_food_x;
                    food_y_d = i_food_y;
                    eat_d    = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == ADDR_W'(CELLS - 1)) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_INIT: begin
                ring_append = 1'b1;
                ring_wx     = X_W'(INIT_LEN - 1) - X_W'(cnt_q);
                ring_wy     = Y_W'(GRID_H / 2);
                head_x_d    = X_W'(INIT_LEN - 1);
                head_y_d    = Y_W'(GRID_H / 2);
                go_d        = 1'b0;
                if (cnt_q == ADDR_W'(INIT_LEN - 1)) state_d = ST_DONE;
                else                                 cnt_d   = cnt_q + ADDR_W'(1);
            end
            ST_CALC: begin
                if (wall_c) begin
                    state_d = ST_OVER;
                end else begin
                    nxt_x_d = calc_x_c;
                    nxt_y_d = calc_y_c;
                    eat_d   = calc_eat_c;
                    cnt_d   = '0;
                    // A single non-growing segment is the tail itself: nothing to scan.
                    if (!(calc_eat_c && !ring_full) && ring_len == LEN_W'(1)) state_d = ST_ERASE;
                    else                                                      state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_x == nxt_x_q && scan_y == nxt_y_q) state_d = ST_OVER;
                else if (cnt_q == scan_last_c)              state_d = grow_c ? ST_DRAW : ST_ERASE;
                else                                        cnt_d   = cnt_q + ADDR_W'(1);
            end
            ST_ERASE: begin
                ring_pop = 1'b1;
                state_d  = ST_DRAW;
            end
            ST_DRAW: begin
                ring_push = 1'b1;
                head_x_d  = nxt_x_q;
                head_y_d  = nxt_y_q;
                state_d   = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_OVER: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // RESET_SNAKE wins from any state, including mid-operation.
        if (rst_cmd_c) begin
            state_d     = ST_CLEAR;
            cnt_d       = '0;
            eat_d       = 1'b0;
            ring_clr    = 1'b1;
            ring_push   = 1'b0;
            ring_pop    = 1'b0;
            ring_append = 1'b0;
        end

        if (state_d == ST_OVER) go_d = 1'b1;

        // Registered grid-write port reflects the state being entered.
        unique case (state_d)
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_d;
            end
            ST_INIT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cell_addr(X_W'(INIT_LEN - 1) - X_W'(cnt_d), Y_W'(GRID_H / 2));
                wr_data_d = 1'b1;
            end
            ST_ERASE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cell_addr(tail_x, tail_y);
            end
            ST_DRAW: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cell_addr(nxt_x_d, nxt_y_d);
                wr_data_d = 1'b1;
            end
            default: ;
        endcase

        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE) || (state_d == ST_OVER);
        eat_pulse_d = (state_d == ST_DONE) && eat_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dir_q       <= '0;
            food_x_q    <= '0;
            food_y_q    <= '0;
            nxt_x_q     <= '0;
            nxt_y_q     <= '0;
            head_x_q    <= '0;
            head_y_q    <= '0;
            eat_q       <= 1'b0;
            go_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            eat_pulse_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            food_x_q    <= food_x_d;
            food_y_q    <= food_y_d;
            nxt_x_q     <= nxt_x_d;
            nxt_y_q     <= nxt_y_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            eat_q       <= eat_d;
            go_q        <= go_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            eat_pulse_q <= eat_pulse_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign o_head_x    = head_x_q;
    assign o_head_y    = head_y_q;
    assign o_len       = 7'(ring_len);
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_eat       = eat_pulse_q;
    assign o_game_over = go_q;
    assign o_wr_en     = wr_en_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;

endmodule
